// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit : iterative RV32M divide / remainder unit (execute stage)
//
// Radix-2 restoring divider that produces one quotient bit per clock. The
// result is handed to the register bank as a write-back triple.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request pulse, sampled only while idle
//   funct3   in   100 DIV, 101 DIVU, 110 REM, 111 REMU, others act as DIVU
//   DataA    in   dividend
//   DataB    in   divisor
//   AddrDIn  in   destination register of the request
//   kill     in   synchronous abort (pipeline flush)
//   busy     out  unit occupied, upstream must hold its request
//   AddrD    out  write-back address
//   DataD    out  write-back data
//   RegWEn   out  one-cycle write enable (suppressed for x0)
//   done     out  one-cycle completion pulse
//
// Optional build macro
//   DIV_EARLY_OUT_EN : divide-by-zero and signed-overflow requests skip the
//                      iteration phase and complete 2 edges after acceptance.
//                      Without it every request completes 34 edges after
//                      acceptance.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH_ADDR_LENGTH = 5,
  parameter int WIDTH_DATA_LENGTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2:0]                   funct3,
  input  logic [WIDTH_DATA_LENGTH-1:0] DataA,
  input  logic [WIDTH_DATA_LENGTH-1:0] DataB,
  input  logic [WIDTH_ADDR_LENGTH-1:0] AddrDIn,
  input  logic                         kill,
  output logic                         busy,
  output logic [WIDTH_ADDR_LENGTH-1:0] AddrD,
  output logic [WIDTH_DATA_LENGTH-1:0] DataD,
  output logic                         RegWEn,
  output logic                         done
);

  localparam int W = WIDTH_DATA_LENGTH;
  localparam int A = WIDTH_ADDR_LENGTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q;
  logic [W-1:0]   q_q, rem_q, div_q;
  logic [A-1:0]   addr_q, addrd_q;
  logic [W-1:0]   datad_q;
  logic           is_rem_q, qneg_q, rneg_q, special_q;
  logic           busy_q, wen_q, done_q;

  // Two's complement negate when neg is set; 0x80000000 maps to itself and is
  // then read as an unsigned magnitude.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Request decode
  logic         accept, sgn_op, rem_op, a_neg, b_neg, dz, ovf, special_in;
  logic [W-1:0] a_abs, b_abs;

  assign accept     = (state_q == IDLE) && !busy_q && start && !kill;
  assign sgn_op     = (funct3 == 3'b100) || (funct3 == 3'b110);
  assign rem_op     = (funct3 == 3'b110) || (funct3 == 3'b111);
  assign a_neg      = sgn_op && DataA[W-1];
  assign b_neg      = sgn_op && DataB[W-1];
  assign a_abs      = cond_neg(DataA, a_neg);
  assign b_abs      = cond_neg(DataB, b_neg);
  assign dz         = (DataB == '0);
  assign ovf        = sgn_op && (DataA == {1'b1, {(W-1){1'b0}}}) && (DataB == '1);
  assign special_in = dz || ovf;

  // Iteration step: the shifted partial remainder is one bit wider than the
  // operands so the compare never wraps.
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         ge;

  assign shifted = {rem_q, q_q[W-1]};
  assign ge      = (shifted >= {1'b0, div_q});
  assign diff    = shifted[W-1:0] - div_q;

  // Sign correction and result select
  logic [W-1:0] result;
  assign result = is_rem_q ? cond_neg(rem_q, rneg_q) : cond_neg(q_q, qneg_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
`ifdef DIV_EARLY_OUT_EN
        state_d = special_in ? FIX : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC: begin
        if (kill)                state_d = IDLE;
        else if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX:  state_d = kill ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      addr_q    <= '0;
      addrd_q   <= '0;
      datad_q   <= '0;
      is_rem_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Outputs trail the state by one cycle; busy stays up through the
      // completion cycle so a new request lands only after it.
      busy_q  <= (state_d != IDLE) || (state_q == DONE);
      done_q  <= (state_q == DONE);
      wen_q   <= (state_q == DONE) && (addrd_q != '0);

      if (accept) begin
        cnt_q     <= '0;
        addr_q    <= AddrDIn;
        is_rem_q  <= rem_op;
        special_q <= special_in;
        // Special cases preload their final answers with no sign fix-up and
        // the iteration holds them untouched.
        if (dz) begin
          q_q    <= '1;
          rem_q  <= DataA;
          qneg_q <= 1'b0;
          rneg_q <= 1'b0;
        end else if (ovf) begin
          q_q    <= {1'b1, {(W-1){1'b0}}};
          rem_q  <= '0;
          qneg_q <= 1'b0;
          rneg_q <= 1'b0;
        end else begin
          q_q    <= a_abs;
          rem_q  <= '0;
          div_q  <= b_abs;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
        end
      end

      if (state_q == CALC) begin
        cnt_q <= cnt_q + 6'd1;
        if (!special_q) begin
          q_q   <= {q_q[W-2:0], ge};
          rem_q <= ge ? diff : shifted[W-1:0];
        end
      end

      if ((state_q == FIX) && !kill) begin
        datad_q <= result;
        addrd_q <= addr_q;
      end
    end
  end

  assign busy   = busy_q;
  assign AddrD  = addrd_q;
  assign DataD  = datad_q;
  assign RegWEn = wen_q;
  assign done   = done_q;

endmodule
